// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_loader
// Description : Accepts an operation command (opcode + 32-bit constant), then
//               streams 32-bit rows into one or two 8x8 matrices of 4-bit
//               items. It presents the assembled operands and a one-hot
//               operation select to a downstream logical unit, and waits for
//               that unit to finish before taking the next command.
// Ports       : clk                 - rising-edge clock
//               reset               - asynchronous active-low reset
//               cmd_valid/op/const  - command handshake in, cmd_ready out
//               line_valid/data     - row handshake in, line_ready out
//               unit_ready          - downstream unit finished
//               readed_lines_count  - rows accepted for current command
//               matrix_a/matrix_b   - assembled operand matrices
//               constant            - registered constant operand
//               dsc..or_            - one-hot operation selects
//               op_error            - one-cycle pulse on illegal opcode
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   input  logic [3:0]   cmd_op,
   input  logic [31:0]  cmd_constant,
   output logic         cmd_ready,
   input  logic         line_valid,
   input  logic [31:0]  line_data,
   output logic         line_ready,
   input  logic         unit_ready,
   output logic [7:0]   readed_lines_count,
   output logic [255:0] matrix_a,
   output logic [255:0] matrix_b,
   output logic [31:0]  constant,
   output logic         dsc,
   output logic         rsr,
   output logic         usc,
   output logic         lsr,
   output logic         awc,
   output logic         and_,
   output logic         xwc,
   output logic         or_,
   output logic         op_error
);

   localparam logic [1:0] c_ST_IDLE      = 2'd0;
   localparam logic [1:0] c_ST_LOAD_A    = 2'd1;
   localparam logic [1:0] c_ST_LOAD_B    = 2'd2;
   localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic [7:0]   r_count;
   logic [255:0] r_matrix_a;
   logic [255:0] r_matrix_b;
   logic [31:0]  r_constant;
   logic [7:0]   r_op_sel;
   logic         r_op_error;
   logic         w_line_acc;
   logic         w_two_operand;
   logic         w_last_row;
   logic [7:0]   w_row_lsb;

   // Opcodes 8..15 all have bit 3 set, so bit 3 alone flags an illegal op.
   assign w_two_operand = r_op_sel[5] | r_op_sel[7];
   assign w_line_acc    = line_valid & line_ready;
   assign w_last_row    = (r_count[2:0] == 3'd7);
   // Row k sits at [255-32k -: 32]; its LSB is 32*(7-k), i.e. {~k, 5'b0}.
   assign w_row_lsb     = {~r_count[2:0], 5'd0};

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (cmd_valid && !cmd_op[3]) begin
               w_state_nxt = c_ST_LOAD_A;
            end
         end
         c_ST_LOAD_A: begin
            if (w_line_acc && w_last_row) begin
               w_state_nxt = w_two_operand ? c_ST_LOAD_B : c_ST_WAIT_DONE;
            end
         end
         c_ST_LOAD_B: begin
            if (w_line_acc && w_last_row) begin
               w_state_nxt = c_ST_WAIT_DONE;
            end
         end
         c_ST_WAIT_DONE: begin
            if (unit_ready) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      cmd_ready  = (r_state == c_ST_IDLE);
      line_ready = (r_state == c_ST_LOAD_A) || (r_state == c_ST_LOAD_B);
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= 8'd0;
         r_matrix_a <= 256'd0;
         r_matrix_b <= 256'd0;
         r_constant <= 32'd0;
         r_op_sel   <= 8'd0;
         r_op_error <= 1'b0;
      end else begin
         r_op_error <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_op[3]) begin
                     r_op_error <= 1'b1;
                  end else begin
                     r_constant <= cmd_constant;
                     r_op_sel   <= 8'd1 << cmd_op[2:0];
                     r_count    <= 8'd0;
                  end
               end
            end
            c_ST_LOAD_A: begin
               if (w_line_acc) begin
                  r_matrix_a[w_row_lsb +: 32] <= line_data;
                  r_count                     <= r_count + 8'd1;
               end
            end
            c_ST_LOAD_B: begin
               // Counts 8..15 share low bits 0..7 with matrix A rows.
               if (w_line_acc) begin
                  r_matrix_b[w_row_lsb +: 32] <= line_data;
                  r_count                     <= r_count + 8'd1;
               end
            end
            c_ST_WAIT_DONE: begin
               if (unit_ready) begin
                  r_op_sel <= 8'd0;
                  r_count  <= 8'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign readed_lines_count = r_count;
   assign matrix_a           = r_matrix_a;
   assign matrix_b           = r_matrix_b;
   assign constant           = r_constant;
   assign op_error           = r_op_error;
   assign dsc                = r_op_sel[0];
   assign rsr                = r_op_sel[1];
   assign usc                = r_op_sel[2];
   assign lsr                = r_op_sel[3];
   assign awc                = r_op_sel[4];
   assign and_               = r_op_sel[5];
   assign xwc                = r_op_sel[6];
   assign or_                = r_op_sel[7];

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_loader
// Description : Self-checking bench for matrix_loader. A transaction-level
//               reference model (active flag, opcode, row count, row arrays)
//               predicts every output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_loader;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic [3:0]   cmd_op;
   logic [31:0]  cmd_constant;
   logic         cmd_ready;
   logic         line_valid;
   logic [31:0]  line_data;
   logic         line_ready;
   logic         unit_ready;
   logic [7:0]   readed_lines_count;
   logic [255:0] matrix_a;
   logic [255:0] matrix_b;
   logic [31:0]  constant;
   logic         dsc, rsr, usc, lsr, awc, and_, xwc, or_;
   logic         op_error;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   bit          m_active;
   int          m_op;
   int          m_count;
   logic [31:0] m_const;
   bit          m_err;
   logic [31:0] m_a [8];
   logic [31:0] m_b [8];

   matrix_loader dut (
      .clk                (clk),
      .reset              (reset),
      .cmd_valid          (cmd_valid),
      .cmd_op             (cmd_op),
      .cmd_constant       (cmd_constant),
      .cmd_ready          (cmd_ready),
      .line_valid         (line_valid),
      .line_data          (line_data),
      .line_ready         (line_ready),
      .unit_ready         (unit_ready),
      .readed_lines_count (readed_lines_count),
      .matrix_a           (matrix_a),
      .matrix_b           (matrix_b),
      .constant           (constant),
      .dsc                (dsc),
      .rsr                (rsr),
      .usc                (usc),
      .lsr                (lsr),
      .awc                (awc),
      .and_               (and_),
      .xwc                (xwc),
      .or_                (or_),
      .op_error           (op_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int need(input int op);
      return (op == 5 || op == 7) ? 16 : 8;
   endfunction

   function automatic logic [255:0] pack(input logic [31:0] rows [8]);
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[255 - 32*k -: 32] = rows[k];
      return v;
   endfunction

   function automatic void model_clear();
      m_active = 0;
      m_op     = 0;
      m_count  = 0;
      m_const  = '0;
      m_err    = 0;
      for (int k = 0; k < 8; k++) begin
         m_a[k] = '0;
         m_b[k] = '0;
      end
   endfunction

   // Effect of one rising edge, computed from the current input values.
   function automatic void model_edge();
      if (!reset) begin
         model_clear();
         return;
      end
      m_err = 0;
      if (!m_active) begin
         if (cmd_valid) begin
            if (cmd_op < 4'd8) begin
               m_active = 1;
               m_op     = int'(cmd_op);
               m_const  = cmd_constant;
               m_count  = 0;
            end else begin
               m_err = 1;
            end
         end
      end else if (m_count < need(m_op)) begin
         if (line_valid) begin
            if (m_count < 8) m_a[m_count] = line_data;
            else             m_b[m_count - 8] = line_data;
            m_count++;
         end
      end else if (unit_ready) begin
         m_active = 0;
         m_count  = 0;
      end
   endfunction

   task automatic check_all(input string where);
      logic [7:0] sel;
      sel = m_active ? 8'(1 << m_op) : 8'd0;
      check({where, ".cmd_ready"},  cmd_ready, !m_active);
      check({where, ".line_ready"}, line_ready, m_active && (m_count < need(m_op)));
      check({where, ".count"},      readed_lines_count, 8'(m_count));
      check({where, ".sel"},        {or_, xwc, and_, awc, lsr, usc, rsr, dsc}, sel);
      check({where, ".op_error"},   op_error, m_err);
      check({where, ".constant"},   constant, m_const);
      check({where, ".matrix_a"},   matrix_a, pack(m_a));
      check({where, ".matrix_b"},   matrix_b, pack(m_b));
   endtask

   task automatic tick(input string where);
      @(posedge clk);
      model_edge();
      #1;
      check_all(where);
   endtask

   // Issue a command and drive randomized traffic until the model returns idle.
   task automatic random_cmd(input int op, input string where);
      int budget;
      cmd_valid    = 1'b1;
      cmd_op       = 4'(op);
      cmd_constant = $urandom;
      tick(where);
      cmd_valid = 1'b0;
      budget    = 0;
      while (m_active && budget < 300) begin
         line_valid   = ($urandom_range(0, 2) != 0);
         line_data    = $urandom;
         unit_ready   = ($urandom_range(0, 3) == 0);
         cmd_valid    = ($urandom_range(0, 3) == 0);
         cmd_op       = 4'($urandom);
         cmd_constant = $urandom;
         tick(where);
         budget++;
      end
      line_valid = 1'b0;
      unit_ready = 1'b0;
      cmd_valid  = 1'b0;
      check({where, ".back_idle"}, cmd_ready, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] sent [$];
      logic [31:0] keep_const;

      reset        = 1'b0;
      cmd_valid    = 1'b0;
      cmd_op       = 4'd0;
      cmd_constant = 32'd0;
      line_valid   = 1'b0;
      line_data    = 32'd0;
      unit_ready   = 1'b0;
      model_clear();
      #1;
      check_all("reset");
      tick("reset_hold");
      tick("reset_hold");

      // awc, contiguous lines; unit_ready held during LOAD_A must be ignored.
      // Reset releases together with cmd_valid: first edge takes the command.
      reset        = 1'b1;
      cmd_valid    = 1'b1;
      cmd_op       = 4'd4;
      cmd_constant = 32'h0F0F0F0F;
      tick("awc_cmd");
      cmd_valid  = 1'b0;
      unit_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         line_valid = 1'b1;
         line_data  = 32'h11111111 * (k + 1);
         tick("awc_line");
      end
      line_valid = 1'b0;
      unit_ready = 1'b0;
      check("awc.sel",     awc, 1'b1);
      check("awc.count",   readed_lines_count, 8'd8);
      check("awc.a_top",   matrix_a[255:224], 32'h11111111);
      check("awc.a_bot",   matrix_a[31:0], 32'h88888888);
      check("awc.const",   constant, 32'h0F0F0F0F);
      check("awc.wait",    {cmd_ready, line_ready}, 2'b00);
      line_valid = 1'b1;           // ignored while waiting
      line_data  = 32'hDEADBEEF;
      tick("awc_wait");
      line_valid = 1'b0;
      unit_ready = 1'b1;
      tick("awc_done");
      unit_ready = 1'b0;
      check("awc.done_cnt", readed_lines_count, 8'd0);
      check("awc.done_rdy", cmd_ready, 1'b1);

      // and_, line_valid toggling; a command during LOAD_B is ignored.
      cmd_valid    = 1'b1;
      cmd_op       = 4'd5;
      cmd_constant = $urandom;
      keep_const   = cmd_constant;
      tick("and_cmd");
      cmd_valid = 1'b0;
      sent.delete();
      for (int i = 0; i < 32; i++) begin
         line_valid = (i % 2 == 0);
         line_data  = $urandom;
         if (line_valid) sent.push_back(line_data);
         cmd_valid    = (i >= 18);
         cmd_op       = 4'd0;
         cmd_constant = ~keep_const;
         tick("and_line");
      end
      cmd_valid  = 1'b0;
      line_valid = 1'b0;
      check("and.count",  readed_lines_count, 8'd16);
      check("and.b_top",  matrix_b[255:224], sent[8]);
      check("and.sel",    and_, 1'b1);
      check("and.dsc",    dsc, 1'b0);
      check("and.const",  constant, keep_const);
      unit_ready = 1'b1;
      tick("and_done");
      unit_ready = 1'b0;

      // illegal opcode
      cmd_valid = 1'b1;
      cmd_op    = 4'd9;
      tick("ill_cmd");
      cmd_valid = 1'b0;
      check("ill.err",   op_error, 1'b1);
      check("ill.ready", cmd_ready, 1'b1);
      check("ill.sel",   {or_, xwc, and_, awc, lsr, usc, rsr, dsc}, 8'd0);
      tick("ill_after");
      check("ill.err_off", op_error, 1'b0);

      // or_ interrupted by reset after 5 lines, then dsc from count 0
      cmd_valid = 1'b1;
      cmd_op    = 4'd7;
      cmd_constant = $urandom;
      tick("or_cmd");
      cmd_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         line_valid = 1'b1;
         line_data  = $urandom;
         tick("or_line");
      end
      line_valid = 1'b0;
      check("or.count5", readed_lines_count, 8'd5);
      reset = 1'b0;
      #1;
      model_clear();
      check_all("async_rst");
      tick("rst_hold");
      reset = 1'b1;
      random_cmd(0, "dsc_after_rst");

      // randomized commands, including illegal opcodes
      for (int n = 0; n < 24; n++) begin
         random_cmd($urandom_range(0, 11), "rand");
         if ($urandom_range(0, 2) == 0) tick("rand_gap");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset.
REQ-002 SHALL provide: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL provide: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL provide: cmd_valid  in  1  a command is present.
REQ-005 SHALL provide: cmd_op  in  4  opcode: 0 dsc, 1 rsr, 2 usc, 3 lsr, 4 awc, 5 and_, 6 xwc, 7 or_; 8-15 are illegal.
REQ-006 SHALL provide: cmd_constant  in  32  constant operand, captured with the command.
REQ-007 SHALL provide: cmd_ready  out  1  block can accept a command.
REQ-008 SHALL provide: line_valid  in  1  a matrix line is present.
REQ-009 SHALL provide: line_data  in  32  one matrix row (8 x 4-bit items).
REQ-010 SHALL provide: line_ready  out  1  block can accept a line.
REQ-011 SHALL provide: unit_ready  in  1  downstream logical unit has finished (its ready output).
REQ-012 SHALL provide: readed_lines_count  out  8  number of lines accepted for the current command.
REQ-013 SHALL provide: matrix_a, matrix_b  out  256 each  assembled operand matrices.
REQ-014 SHALL provide: constant  out  32  registered constant operand.
REQ-015 SHALL provide: dsc, rsr, usc, lsr, awc, and_, xwc, or_  out  1 each  one-hot operation selects.
REQ-016 SHALL provide: op_error  out  1  one-cycle pulse on an illegal opcode.

Function
REQ-017 SHALL implement the states IDLE, LOAD_A, LOAD_B and WAIT_DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; line_ready SHALL be 1 only in LOAD_A and LOAD_B; both SHALL be combinational decodes of the state.
REQ-019 IDLE with cmd_valid=1 and a legal opcode SHALL capture cmd_op and cmd_constant, set readed_lines_count=0, assert the matching op select, and move to LOAD_A at the next edge.
REQ-020 IDLE with cmd_valid=1 and an illegal opcode SHALL pulse op_error for exactly one cycle, leave all op selects at 0, and stay in IDLE.
REQ-021 A line SHALL be accepted on an edge where line_valid and line_ready are both 1; no other edge counts as an acceptance.
REQ-022 Line k of a matrix (k = 0..7, in arrival order) SHALL be written to bits [255-32k -: 32], so line 0 occupies [255:224].
REQ-023 Each accepted line SHALL increment readed_lines_count by 1 on the same edge that writes the row, so the count and the data become visible together.
REQ-024 LOAD_A SHALL fill matrix_a; after the 8th line it SHALL go to LOAD_B for and_/or_, or to WAIT_DONE for all other ops.
REQ-025 LOAD_B SHALL fill matrix_b (counts 9..16 map to k = 0..7) and, after the 16th line, go to WAIT_DONE.
REQ-026 Final readed_lines_count SHALL be 8 for single-operand ops and 16 for and_/or_, and SHALL never exceed 16.
REQ-027 Op selects SHALL stay one-hot and stable from LOAD_A through WAIT_DONE, and SHALL be 0 in IDLE.
REQ-028 WAIT_DONE with unit_ready=1 SHALL, at the next edge, return to IDLE, clear the op selects and clear readed_lines_count.
REQ-029 unit_ready SHALL be ignored outside WAIT_DONE.
REQ-030 cmd_valid SHALL be ignored outside IDLE.
REQ-031 line_valid SHALL be ignored in IDLE and WAIT_DONE.
REQ-032 matrix_a, matrix_b and constant SHALL hold their values until overwritten by a new line or command.
REQ-033 Rows of matrix_a that have not yet been written in the current command SHALL keep their previous contents.

Reset
REQ-034 reset=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, readed_lines_count=0, matrix_a=0, matrix_b=0, constant=0, all op selects=0, op_error=0.
REQ-035 Reset asserted mid-load or during WAIT_DONE SHALL abandon the command; no partial command SHALL resume after reset releases.
REQ-036 The first command SHALL be accepted on the first rising edge on which reset=1 and cmd_valid=1.

Verification
REQ-037 SHALL check: cmd_op=4, cmd_constant=0x0F0F0F0F, lines 0x11111111..0x88888888 with no gaps -> awc=1, count=8, matrix_a[255:224]=0x11111111, matrix_a[31:0]=0x88888888, state WAIT_DONE.
REQ-038 SHALL check: cmd_op=5, 16 lines, with line_valid toggling every other cycle -> count steps 1..16 only on handshakes, matrix_b[255:224]=line 9, and_=1 throughout.
REQ-039 SHALL check: cmd_op=9 -> op_error high for exactly 1 cycle, cmd_ready stays 1, all op selects 0.
REQ-040 SHALL check: reset=0 after 5 lines of an or_ command -> all outputs are 0 asynchronously, and a following dsc command loads from count 0.
REQ-041 SHALL check: unit_ready=1 during LOAD_A, then unit_ready=1 in WAIT_DONE -> the first is ignored; the second returns to IDLE the next cycle with count=0.
REQ-042 SHALL check: cmd_valid=1 during LOAD_B -> the command is not captured, and the op and constant are unchanged.
